// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: ALU and load sources toward the regfile arbiter.
// The master drives valid/addr/data and the slave answers with ready.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [4:0]        alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [4:0]        mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter (ALU vs load) with a pending-write scoreboard.
// Define RFWB_ROUND_ROBIN_EN for round-robin arbitration; default is mem over alu.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave wb,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dst,
    output logic               rf_write,
    output logic [4:0]         rf_write_address,
    output logic [DATA_W-1:0]  rf_write_data,
    output logic [31:0]        busy
);
    logic              alu_req;
    logic              mem_req;
    logic              grant_alu;
    logic              grant_mem;
    logic              wb_fire;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       busy_next;

    assign alu_req = wb.alu_valid && !reset;
    assign mem_req = wb.mem_valid && !reset;

`ifdef RFWB_ROUND_ROBIN_EN
    // Set when the ALU took the most recent grant; mem wins the next tie.
    logic alu_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_last <= 1'b1;
        end else if (wb_fire) begin
            alu_last <= grant_alu;
        end
    end

    assign grant_mem = mem_req && (!alu_req || alu_last);
`else
    assign grant_mem = mem_req;
`endif

    assign grant_alu    = alu_req && !grant_mem;
    assign wb.alu_ready = grant_alu;
    assign wb.mem_ready = grant_mem;
    assign wb_fire      = grant_alu || grant_mem;
    assign wb_addr      = grant_mem ? wb.mem_addr : wb.alu_addr;
    assign wb_data      = grant_mem ? wb.mem_data : wb.alu_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write         <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else begin
            rf_write <= wb_fire && (wb_addr != 5'd0);
            if (wb_fire && (wb_addr != 5'd0)) begin
                rf_write_address <= wb_addr;
                rf_write_data    <= wb_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        busy_next = busy;
        if (wb_fire && (wb_addr != 5'd0)) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_valid && !reset && (issue_dst != 5'd0)) begin
            busy_next[issue_dst] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + random bench for regfile_wb_arbiter with a write scoreboard.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        rf_write;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic [31:0] busy;

    regfile_wb_arbiter_if #(.DATA_W(32)) wb ();

    regfile_wb_arbiter #(.DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb               (wb),
        .issue_valid      (issue_valid),
        .issue_dst        (issue_dst),
        .rf_write         (rf_write),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] m_busy = '0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_alu_last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cycle(
        input logic        av, input logic [4:0] aa, input logic [31:0] ad,
        input logic        mv, input logic [4:0] ma, input logic [31:0] md,
        input logic        iv, input logic [4:0] id, input logic rst,
        input string       tag
    );
        logic        e_mem;
        logic        e_alu;
        logic        hs;
        logic [4:0]  ha;
        logic [31:0] hd;
        wr_t         e;
        wb.alu_valid = av;
        wb.alu_addr  = aa;
        wb.alu_data  = ad;
        wb.mem_valid = mv;
        wb.mem_addr  = ma;
        wb.mem_data  = md;
        issue_valid  = iv;
        issue_dst    = id;
        reset        = rst;
        #4;
`ifdef RFWB_ROUND_ROBIN_EN
        e_mem = mv && !rst && (!av || m_alu_last);
`else
        e_mem = mv && !rst;
`endif
        e_alu = av && !rst && !e_mem;
        hs    = e_mem || e_alu;
        ha    = e_mem ? ma : aa;
        hd    = e_mem ? md : ad;
        chk({tag, " alu_ready"}, 64'(wb.alu_ready), 64'(e_alu));
        chk({tag, " mem_ready"}, 64'(wb.mem_ready), 64'(e_mem));
        if (rst) begin
            m_addr = '0;
            m_data = '0;
            e = '{w: 1'b0, a: 5'd0, d: 32'd0};
        end else if (hs && ha != 5'd0) begin
            m_addr = ha;
            m_data = hd;
            e = '{w: 1'b1, a: ha, d: hd};
        end else begin
            e = '{w: 1'b0, a: m_addr, d: m_data};
        end
        sb.push_back(e);
        if (rst) begin
            m_busy     = '0;
            m_alu_last = 1'b1;
        end else begin
            if (hs && ha != 5'd0) m_busy[ha] = 1'b0;
            if (iv && id != 5'd0) m_busy[id] = 1'b1;
            if (hs) m_alu_last = e_alu;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " rf_write"}, 64'(rf_write), 64'(e.w));
            chk({tag, " rf_addr"}, 64'(rf_write_address), 64'(e.a));
            chk({tag, " rf_data"}, 64'(rf_write_data), 64'(e.d));
        end
        chk({tag, " busy"}, 64'(busy), 64'(m_busy));
    endtask

    initial begin
        reset        = 1'b1;
        wb.alu_valid = 1'b0;
        wb.alu_addr  = '0;
        wb.alu_data  = '0;
        wb.mem_valid = 1'b0;
        wb.mem_addr  = '0;
        wb.mem_data  = '0;
        issue_valid  = 1'b0;
        issue_dst    = '0;
        @(posedge clk);
        #1;
        do_cycle(0, 0, 0, 1, 3, 32'h1, 1, 3, 1, "rst0");
        do_cycle(1, 2, 32'h7, 0, 0, 0, 0, 0, 1, "rst1");
        do_cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, "alu_only");
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_hold");
        do_cycle(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, "both_c1");
        do_cycle(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, "both_c2");
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, "held");
        end
        do_cycle(0, 0, 0, 1, 8, 32'h88, 0, 0, 0, "mem_only");
        do_cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, "issue7");
        do_cycle(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, "set_wins");
        do_cycle(1, 0, 32'h5, 0, 0, 0, 1, 0, 0, "dst0");
        do_cycle(0, 0, 0, 1, 7, 32'h70, 0, 0, 0, "clear7");
        do_cycle(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, "not_busy");
        for (int r = 4; r < 8; r++) begin
            do_cycle(0, 0, 0, 0, 0, 0, 1, 5'(r), 0, "build_f0");
        end
        do_cycle(1, 12, 32'hC0, 0, 0, 0, 0, 0, 0, "pre_rst");
        do_cycle(1, 13, 32'hD0, 1, 14, 32'hE0, 1, 9, 1, "mid_rst");
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
        for (int i = 0; i < 60; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 15) == 0), "rand");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
